// File: rtl/cascade_counter_chain_pkg.sv
// Shared definitions for the cascaded counter chain.
// Holds the FSM state type, the default parameter values and the raw
// state codes presented on the STATE output.
package cascade_counter_pkg;

    localparam int DEF_NUM_STAGES = 3;
    localparam int DEF_STAGE_W    = 4;
    localparam int DEF_SATURATE   = 0;

    localparam logic [1:0] IDLE_CODE = 2'd0;
    localparam logic [1:0] RUN_CODE  = 2'd1;
    localparam logic [1:0] HOLD_CODE = 2'd2;
    localparam logic [1:0] DONE_CODE = 2'd3;

    typedef enum logic [1:0] {
        IDLE = IDLE_CODE,
        RUN  = RUN_CODE,
        HOLD = HOLD_CODE,
        DONE = DONE_CODE
    } state_t;

endpackage

// File: rtl/cascade_counter_chain_stage.sv
// One STAGE_W-bit up/down counter stage of the cascade.
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous active-high reset (q -> 0)
//   clr      - synchronous clear (q -> 0)
//   load     - parallel load of load_val (below rst/clr in priority)
//   load_val - value for load
//   cin      - carry/borrow in: step this stage by one this cycle
//   dir      - 0 = count up, 1 = count down
//   q        - registered stage value
//   tc       - combinational terminal flag for the current direction
module counter_stage
    import cascade_counter_pkg::*;
#(
    parameter int STAGE_W = DEF_STAGE_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               load,
    input  logic [STAGE_W-1:0] load_val,
    input  logic               cin,
    input  logic               dir,
    output logic [STAGE_W-1:0] q,
    output logic               tc
);

    localparam logic [STAGE_W-1:0] ONE = STAGE_W'(1);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (cin) begin
            q <= dir ? (q - ONE) : (q + ONE);
        end
    end

    // Terminal is all-ones going up and zero going down; follows dir at once.
    assign tc = dir ? (q == '0) : (q == '1);

endmodule

// File: rtl/cascade_counter_chain.sv
// Cascaded ripple-carry counter chain with a small run-control FSM.
// NUM_STAGES counter_stage instances form one NUM_STAGES*STAGE_W-bit
// counter; stage k only steps when every lower stage sits at terminal.
// Ports:
//   CK       - clock, rising edge
//   RST      - synchronous active-high reset (highest priority)
//   EN       - count enable
//   CLR      - synchronous clear of count, state and WRAP
//   DIR      - 0 = up, 1 = down
//   LOAD     - parallel load strobe (below CLR)
//   LOAD_VAL - load value, stage 0 in the LSBs
//   COUNT    - registered chain value
//   STAGE_TC - per-stage combinational terminal flags
//   WRAP     - one-cycle registered pulse on full-chain rollover
//   STATE    - FSM state code (IDLE=0, RUN=1, HOLD=2, DONE=3)
module cascade_counter_chain
    import cascade_counter_pkg::*;
#(
    parameter int NUM_STAGES = DEF_NUM_STAGES,
    parameter int STAGE_W    = DEF_STAGE_W,
    parameter int SATURATE   = DEF_SATURATE
) (
    input  logic                          CK,
    input  logic                          RST,
    input  logic                          EN,
    input  logic                          CLR,
    input  logic                          DIR,
    input  logic                          LOAD,
    input  logic [NUM_STAGES*STAGE_W-1:0] LOAD_VAL,
    output logic [NUM_STAGES*STAGE_W-1:0] COUNT,
    output logic [NUM_STAGES-1:0]         STAGE_TC,
    output logic                          WRAP,
    output logic [1:0]                    STATE
);

    localparam bit SAT = (SATURATE != 0);

    state_t                  state;
    state_t                  state_nx;
    logic                    step_en;
    logic                    full_tc;
    logic                    chain_go;
    logic                    rollover;
    logic [NUM_STAGES-1:0]   carry;

    assign full_tc = &STAGE_TC;

    // State register
    always_ff @(posedge CK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; CLR and LOAD override normal sequencing.
    always_comb begin
        state_nx = state;
        if (CLR) begin
            state_nx = IDLE;
        end else if (LOAD) begin
            if (state == DONE) begin
                state_nx = HOLD;
            end
        end else begin
            case (state)
                IDLE: if (EN) state_nx = RUN;
                RUN: begin
                    if (!EN) begin
                        state_nx = HOLD;
                    end else if (SAT && full_tc) begin
                        state_nx = DONE;
                    end
                end
                HOLD: if (EN) state_nx = RUN;
                DONE: state_nx = DONE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        STATE   = state;
        step_en = (state == RUN) && EN && !CLR && !LOAD;
    end

    // A saturating chain at full terminal must not move, so the whole
    // carry chain is suppressed rather than letting it wrap.
    assign chain_go = step_en && !(SAT && full_tc);
    assign rollover = chain_go && full_tc;

    genvar k;
    generate
        for (k = 0; k < NUM_STAGES; k++) begin : g_stage
            if (k == 0) begin : g_c0
                assign carry[k] = chain_go;
            end else begin : g_ck
                assign carry[k] = carry[k-1] & STAGE_TC[k-1];
            end

            counter_stage #(
                .STAGE_W (STAGE_W)
            ) u_stage (
                .clk      (CK),
                .rst      (RST),
                .clr      (CLR),
                .load     (LOAD),
                .load_val (LOAD_VAL[k*STAGE_W +: STAGE_W]),
                .cin      (carry[k]),
                .dir      (DIR),
                .q        (COUNT[k*STAGE_W +: STAGE_W]),
                .tc       (STAGE_TC[k])
            );
        end
    endgenerate

    // WRAP lands on the same edge as the wrapped COUNT.
    always_ff @(posedge CK) begin
        if (RST || CLR || LOAD) begin
            WRAP <= 1'b0;
        end else begin
            WRAP <= rollover;
        end
    end

endmodule

// File: tb/tb_cascade_counter_chain.sv
// Three instances share control inputs: default (3x4, wrap), saturating
// (3x4) and a single 1-bit stage. Each is compared every cycle against an
// integer-valued reference model.
module tb_cascade_counter_chain;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic        clr = 1'b0;
    logic        dir = 1'b0;
    logic        load = 1'b0;
    logic [11:0] lv12 = '0;
    logic [0:0]  lv1 = '0;

    logic [11:0] cnt_a, cnt_b;
    logic [0:0]  cnt_c;
    logic [2:0]  tc_a, tc_b;
    logic [0:0]  tc_c;
    logic        wrap_a, wrap_b, wrap_c;
    logic [1:0]  st_a, st_b, st_c;

    int passed = 0;
    int total  = 0;

    int mn [3] = '{3, 3, 1};
    int mw [3] = '{4, 4, 1};
    int ms [3] = '{0, 1, 0};
    int m_cnt [3];
    int m_st [3];
    int m_wrap [3];

    always #5 clk = ~clk;

    cascade_counter_chain u_a (
        .CK(clk), .RST(rst), .EN(en), .CLR(clr), .DIR(dir), .LOAD(load),
        .LOAD_VAL(lv12), .COUNT(cnt_a), .STAGE_TC(tc_a), .WRAP(wrap_a), .STATE(st_a)
    );

    cascade_counter_chain #(.SATURATE(1)) u_b (
        .CK(clk), .RST(rst), .EN(en), .CLR(clr), .DIR(dir), .LOAD(load),
        .LOAD_VAL(lv12), .COUNT(cnt_b), .STAGE_TC(tc_b), .WRAP(wrap_b), .STATE(st_b)
    );

    cascade_counter_chain #(.NUM_STAGES(1), .STAGE_W(1), .SATURATE(0)) u_c (
        .CK(clk), .RST(rst), .EN(en), .CLR(clr), .DIR(dir), .LOAD(load),
        .LOAD_VAL(lv1), .COUNT(cnt_c), .STAGE_TC(tc_c), .WRAP(wrap_c), .STATE(st_c)
    );

    // Reference: the chain is one integer modulo 2^(n*w); states 0..3 are
    // IDLE/RUN/HOLD/DONE.
    task automatic model_edge();
        int  maxv;
        bit  full;
        for (int i = 0; i < 3; i++) begin
            maxv = (1 << (mn[i] * mw[i])) - 1;
            full = dir ? (m_cnt[i] == 0) : (m_cnt[i] == maxv);
            m_wrap[i] = 0;
            if (rst || clr) begin
                m_cnt[i] = 0;
                m_st[i]  = 0;
            end else if (load) begin
                m_cnt[i] = (i == 2) ? int'(lv1) : int'(lv12);
                if (m_st[i] == 3) m_st[i] = 2;
            end else begin
                case (m_st[i])
                    0: if (en) m_st[i] = 1;
                    1: begin
                        if (!en) begin
                            m_st[i] = 2;
                        end else if (full) begin
                            if (ms[i] != 0) begin
                                m_st[i] = 3;
                            end else begin
                                m_cnt[i]  = dir ? maxv : 0;
                                m_wrap[i] = 1;
                            end
                        end else begin
                            m_cnt[i] = dir ? m_cnt[i] - 1 : m_cnt[i] + 1;
                        end
                    end
                    2: if (en) m_st[i] = 1;
                    default: ;
                endcase
            end
        end
    endtask

    function automatic int exp_tc(int i);
        int r = 0;
        int mask = (1 << mw[i]) - 1;
        int s;
        for (int k = 0; k < mn[i]; k++) begin
            s = (m_cnt[i] >> (k * mw[i])) & mask;
            if (dir ? (s == 0) : (s == mask)) r |= (1 << k);
        end
        return r;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
        total++;
        assert (obs === expv) begin
            passed++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic check_all(string tag);
        check({tag, "/a.count"}, 32'(cnt_a),  32'(m_cnt[0]));
        check({tag, "/a.state"}, 32'(st_a),   32'(m_st[0]));
        check({tag, "/a.wrap"},  32'(wrap_a), 32'(m_wrap[0]));
        check({tag, "/a.tc"},    32'(tc_a),   32'(exp_tc(0)));
        check({tag, "/b.count"}, 32'(cnt_b),  32'(m_cnt[1]));
        check({tag, "/b.state"}, 32'(st_b),   32'(m_st[1]));
        check({tag, "/b.wrap"},  32'(wrap_b), 32'(m_wrap[1]));
        check({tag, "/b.tc"},    32'(tc_b),   32'(exp_tc(1)));
        check({tag, "/c.count"}, 32'(cnt_c),  32'(m_cnt[2]));
        check({tag, "/c.state"}, 32'(st_c),   32'(m_st[2]));
        check({tag, "/c.wrap"},  32'(wrap_c), 32'(m_wrap[2]));
        check({tag, "/c.tc"},    32'(tc_c),   32'(exp_tc(2)));
    endtask

    task automatic tick(string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic set_in(bit r, bit e, bit c, bit d, bit l, logic [11:0] v);
        rst = r; en = e; clr = c; dir = d; load = l; lv12 = v; lv1 = v[0];
    endtask

    initial begin
        int pick;
        logic [11:0] near [4] = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};

        // Reset, then flag polarity for both directions
        set_in(1, 0, 0, 0, 0, 12'h0);
        tick("reset");
        check("reset_tc_up", 32'(tc_a), 32'h0);
        dir = 1'b1;
        #1;
        check("reset_tc_down", 32'(tc_a), 32'h7);
        check("reset_tc_down_c", 32'(tc_c), 32'h1);

        // Defaults: 18 enabled cycles from reset
        set_in(0, 1, 0, 0, 0, 12'h0);
        tick("first_en");
        check("idle_to_run", 32'(st_a), 32'h1);
        check("no_step_on_entry", 32'(cnt_a), 32'h0);
        for (int i = 0; i < 17; i++) begin
            tick("count_up");
            if (i == 15) check("tc_at_0x010", 32'(tc_a), 32'h0);
        end
        check("count_after_17", 32'(cnt_a), 32'h011);

        // Load near the top and roll over / saturate
        set_in(0, 1, 0, 0, 1, 12'hFFE);
        tick("load_ffe");
        set_in(0, 1, 0, 0, 0, 12'h0);
        tick("to_fff");
        check("at_fff", 32'(cnt_a), 32'hFFF);
        tick("rollover");
        check("wrap_count", 32'(cnt_a), 32'h000);
        check("wrap_pulse", 32'(wrap_a), 32'h1);
        check("sat_done", 32'(st_b), 32'h3);
        check("sat_hold", 32'(cnt_b), 32'hFFF);
        check("sat_no_wrap", 32'(wrap_b), 32'h0);
        tick("after_wrap");
        check("wrap_one_cycle", 32'(wrap_a), 32'h0);
        set_in(0, 1, 1, 0, 0, 12'h0);
        tick("clear");
        check("clr_state", 32'(st_b), 32'h0);

        // Count down across a stage boundary, then underflow
        set_in(0, 1, 0, 1, 1, 12'h100);
        tick("load_100");
        set_in(0, 1, 0, 1, 0, 12'h0);
        tick("enter_run");
        tick("down_step");
        check("down_0ff", 32'(cnt_a), 32'h0FF);
        set_in(0, 1, 0, 1, 1, 12'h000);
        tick("load_000");
        set_in(0, 1, 0, 1, 0, 12'h0);
        tick("underflow");
        check("underflow_fff", 32'(cnt_a), 32'hFFF);
        check("underflow_wrap", 32'(wrap_a), 32'h1);

        // Priority and hold/resume
        set_in(1, 1, 1, 0, 1, 12'h5A5);
        tick("rst_all");
        set_in(0, 1, 0, 0, 0, 12'h0);
        tick("rerun");
        tick("step");
        set_in(0, 1, 1, 0, 1, 12'h5A5);
        tick("clr_load");
        check("clr_beats_load", 32'(cnt_a), 32'h0);
        set_in(0, 1, 0, 0, 0, 12'h0);
        for (int i = 0; i < 4; i++) tick("run_again");
        en = 1'b0;
        tick("hold");
        check("hold_state", 32'(st_a), 32'h2);
        tick("hold_frozen");
        en = 1'b1;
        tick("resume_entry");
        tick("resume_step");

        // Randomised run
        for (int n = 0; n < 600; n++) begin
            rst  = ($urandom_range(0, 59) == 0);
            clr  = ($urandom_range(0, 39) == 0);
            load = ($urandom_range(0, 14) == 0);
            en   = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 9) == 0) dir = ~dir;
            pick = $urandom_range(0, 5);
            lv12 = (pick < 4) ? near[pick] : 12'($urandom);
            lv1  = lv12[0];
            tick("random");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/cascade_counter_chain.md
CASCADE_COUNTER_CHAIN -- requirements
Module: cascade_counter_chain

Interface
REQ-001 SHALL provide parameter NUM_STAGES, default 3, number of cascaded counter stages (1..8).
REQ-002 SHALL provide parameter STAGE_W, default 4, bits per stage (1..16).
REQ-003 SHALL provide parameter SATURATE, default 0, where 0 means wrap at full-chain terminal count and 1 means stop in DONE.
REQ-004 SHALL have one clock and a synchronous, active-high reset.
REQ-005 Port CK  input  1  clock; all state updates on its rising edge.
REQ-006 Port RST  input  1  synchronous active-high reset.
REQ-007 Port EN  input  1  count enable.
REQ-008 Port CLR  input  1  synchronous clear of count and state.
REQ-009 Port DIR  input  1  count direction: 0 = up, 1 = down.
REQ-010 Port LOAD  input  1  parallel load strobe.
REQ-011 Port LOAD_VAL  input  NUM_STAGES*STAGE_W  load value; stage 0 is the LSBs.
REQ-012 Port COUNT  output  NUM_STAGES*STAGE_W  registered chain value.
REQ-013 Port STAGE_TC  output  NUM_STAGES  per-stage terminal flag.
REQ-014 Port WRAP  output  1  one-cycle registered pulse on full-chain rollover.
REQ-015 Port STATE  output  2  FSM state code.

Function
REQ-016 Each stage's terminal value SHALL be all-ones when DIR=0 and zero when DIR=1.
REQ-017 STAGE_TC[k] SHALL be combinational and high when stage k equals its terminal value for the current DIR.
REQ-018 The FSM SHALL use IDLE=0, RUN=1, HOLD=2 and DONE=3.
REQ-019 Transitions SHALL be: IDLE->RUN on EN; RUN->HOLD on !EN; HOLD->RUN on EN; RUN->DONE on step-at-full-terminal only when SATURATE=1; DONE exits only on CLR, LOAD or RST.
REQ-020 The chain SHALL step only in a cycle where STATE=RUN and EN=1; the IDLE->RUN edge itself SHALL NOT step.
REQ-021 On a step, stage 0 SHALL change by ±1 mod 2^STAGE_W.
REQ-022 On a step, stage k>0 SHALL change only when all of stages 0..k-1 are at terminal, i.e. a ripple carry/borrow.
REQ-023 Full-chain step when all stages are at terminal, with SATURATE=0: COUNT SHALL wrap to all-zeros (up) or all-ones (down), WRAP=1 next cycle, STATE stays RUN.
REQ-024 Full-chain step when all stages are at terminal, with SATURATE=1: COUNT SHALL hold, STATE->DONE, WRAP stays 0.
REQ-025 Priority each cycle SHALL be RST > CLR > LOAD > step.
REQ-026 CLR SHALL set COUNT=0, STATE=IDLE and WRAP=0.
REQ-027 LOAD SHALL set COUNT=LOAD_VAL with no step that cycle; state is unchanged except DONE->HOLD.
REQ-028 A DIR change SHALL take effect on the next step with no glitch step, and terminal flags SHALL re-evaluate immediately.
REQ-029 Latency from an EN-qualified RUN cycle to the COUNT update SHALL be 1 cycle.
REQ-030 Latency from a rollover step to the WRAP pulse SHALL be 1 cycle (same edge as COUNT).

Reset
REQ-031 RST SHALL set COUNT=0, STATE=IDLE and WRAP=0, overriding all other inputs.
REQ-032 RST asserted mid-RUN SHALL abort counting with no partial ripple retained.
REQ-033 STAGE_TC after reset SHALL follow REQ-017 (DIR=0 gives all 0; DIR=1 gives all 1).

Structure
REQ-034 The shared package cascade_counter_pkg SHALL hold the state typedef (IDLE/RUN/HOLD/DONE), the default parameter constants and the state-code constants.
REQ-035 The block SHALL instantiate sub-module counter_stage (STAGE_W-bit up/down register with load, clear, carry-in, terminal-out) NUM_STAGES times via generate.
REQ-036 Top level SHALL hold only the FSM, the carry chain and the WRAP register.

Verification
REQ-037 Defaults: RST, then EN=1 for 18 cycles, DIR=0 -> STATE=RUN after 1 cycle; COUNT=0x011 after 17 steps; STAGE_TC=3'b000 at 0x00F->0x010 boundary.
REQ-038 SATURATE=0: LOAD 0xFFE, EN=1, DIR=0 -> 0xFFF, then 0x000 with WRAP=1 for exactly one cycle.
REQ-039 SATURATE=1: LOAD 0xFFE, EN=1 -> 0xFFF, then STATE=DONE, COUNT holds 0xFFF; CLR -> COUNT=0, STATE=IDLE.
REQ-040 DIR=1: LOAD 0x100, one step -> COUNT=0x0FF; from 0x000 (SATURATE=0) -> 0xFFF with WRAP=1.
REQ-041 Same-cycle RST+CLR+LOAD+EN -> reset values; CLR+LOAD -> COUNT=0; EN drop mid-RUN -> HOLD with COUNT frozen, re-EN resumes.
REQ-042 NUM_STAGES=1, STAGE_W=1: toggles 0,1,0 with WRAP on each 1->0 transition.
